mem_seq: RTL
============

# mem_seq

Memory access sequencer: the initiator side of the CPU data-memory interface. It accepts one read or write request at a time over a valid/ready handshake. It drives the memory block's address-register load (ADDR, srcA, wAR), write strobe (wM) and write data (R), and returns read data from M as a one-cycle response pulse. It sits between the control unit (or a debug/loader master) and MEMORY, and hides the AR-load / synchronous-read latency and the indirect (pointer) addressing sequence.

## Interface
Parameters:
- READ_LAT, 1: RAM read latency in cycles after AR is loaded (≥1); sets the length of the PWAIT and DWAIT states.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept a request
- req_we  in  1  1 = write, 0 = read
- req_ind  in  1  1 = indirect: the effective address is mem[req_addr]
- req_addr  in  8  direct address or pointer address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_data  out  8  read data, registered; unchanged by writes
- mem_addr  out  8  to MEMORY ADDR
- mem_srcA  out  1  to MEMORY srcA (0 = ADDR, 1 = M)
- mem_wAR  out  1  to MEMORY wAR
- mem_wM  out  1  to MEMORY wM
- mem_R  out  8  to MEMORY R
- mem_M  in  8  from MEMORY M

## Operation
- Accept when req_valid && req_ready. Latch req_we, req_ind, req_addr and req_wdata into internal registers. The request inputs are don't-care after acceptance.
- States: IDLE, LDAR, PWAIT, LDIND, DWAIT, CAP, WR, RSP.
- IDLE: req_ready=1. On accept, go to LDAR.
- LDAR: mem_wAR=1, mem_srcA=0, mem_addr=latched addr. Next state is PWAIT if ind, else WR if we, else DWAIT.
- PWAIT: stays READ_LAT cycles (down-counter), then LDIND.
- LDIND: mem_wAR=1, mem_srcA=1, so the pointer on mem_M is loaded into AR. Next state is WR if we, else DWAIT.
- DWAIT: stays READ_LAT cycles, then CAP.
- CAP: rsp_data <= mem_M. Next state RSP.
- WR: mem_wM=1, mem_R=latched wdata. Next state RSP.
- RSP: rsp_valid=1 for exactly one cycle. Next state IDLE.
- Outside the states listed above, mem_wAR, mem_wM and mem_srcA are 0. mem_addr and mem_R hold their latched values.
- No response backpressure: rsp_valid is never extended.

## Timing
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0x00, mem_wAR=0, mem_wM=0, mem_srcA=0, mem_addr=0x00, mem_R=0x00, wait counter 0.
- Latency is counted in cycles after the accepting edge, with READ_LAT=1:
  - direct read: rsp_valid in cycle 4
  - direct write: cycle 3
  - indirect read: cycle 6
  - indirect write: cycle 5
- Each additional READ_LAT cycle adds 1 per wait state traversed.
- Back-to-back: the next request can be accepted at the earliest on the edge ending the first IDLE cycle after RSP. Throughput is one request per (latency+1) cycles.
- mem_wM is asserted in exactly one cycle per write. mem_wAR is asserted once (direct) or twice (indirect) per request.
- Reset mid-operation: return to the reset values immediately (asynchronous). No rsp_valid and no mem_wM are issued for the aborted request.
- Address arithmetic: none. All 8-bit, natural wrap; a pointer value of 0xFF is legal.

## Configuration
- HRM_MEMSEQ_INDIRECT_EN defined: indirect addressing supported as described.
- Not defined: PWAIT and LDIND are removed, req_ind is ignored (treated as 0), and mem_srcA is tied to 0. An indirect request then behaves as a direct access to req_addr.

## Structure
- The state encodings (3-bit localparams) and the op-flag bit positions go in a shared include, memseq_defs.vh, so the control unit and benches can decode state for debug.
- One sub-module is natural: lat_cnt, a loadable down-counter of width $clog2(READ_LAT+1) with a zero flag, shared by PWAIT and DWAIT.
- Everything else stays in mem_seq.

## Test plan
Memory preloaded with mem[0x10]=0x20, mem[0x20]=0x5A; READ_LAT=1, paired with MEMORY:
- Direct read of 0x20: rsp_valid in cycle 4 for one cycle, rsp_data=0x5A, mem_wM never high.
- Indirect read of 0x10: mem_wAR high in cycles 1 and 3 (srcA 0 then 1), rsp_valid in cycle 6, rsp_data=0x5A.
- Direct write of 0x30, data 0xC3: mem_wM high only in cycle 2 with mem_R=0xC3. A following direct read of 0x30 returns 0xC3, and rsp_data is unchanged by the write.
- Indirect write via 0x10, data 0x11: rsp_valid in cycle 5. A following direct read of 0x20 returns 0x11, and mem[0x10] is still 0x20.
- rst_n pulsed low during DWAIT: outputs go to reset values within the cycle, no rsp_valid follows, and req_ready=1 after release.
- Macro undefined, indirect read of 0x10: behaves as direct, rsp_valid in cycle 4, rsp_data=0x20.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encodings, op-flag bit positions and the latched
// request payload for the memory access sequencer. Imported by the control
// unit and benches so they can decode sequencer state for debug.
package mem_seq_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  // Op-flag bit positions inside req_t.op
  localparam int unsigned OPF_WE  = 0;
  localparam int unsigned OPF_IND = 1;
  localparam int unsigned OPF_W   = 2;

  // Sequencer states (3-bit encodings are stable for debug decode)
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LDAR  = 3'd1,
    ST_PWAIT = 3'd2,
    ST_LDIND = 3'd3,
    ST_DWAIT = 3'd4,
    ST_CAP   = 3'd5,
    ST_WR    = 3'd6,
    ST_RSP   = 3'd7
  } state_e;

  // Request captured at the accepting edge
  typedef struct packed {
    logic [OPF_W-1:0]  op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Width of the wait counter for a given RAM read latency
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: request/response handshake plus the MEMORY-side port of the
// sequencer. slave = sequencer view, master = requester/memory view.
interface mem_seq_if;
  import mem_seq_pkg::*;

  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_ind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // response channel
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  // MEMORY port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_srcA;
  logic              mem_wAR;
  logic              mem_wM;
  logic [DATA_W-1:0] mem_R;
  logic [DATA_W-1:0] mem_M;

  modport slave (
    input  req_valid, req_we, req_ind, req_addr, req_wdata, mem_M,
    output req_ready, rsp_valid, rsp_data,
    output mem_addr, mem_srcA, mem_wAR, mem_wM, mem_R
  );

  modport master (
    output req_valid, req_we, req_ind, req_addr, req_wdata, mem_M,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_addr, mem_srcA, mem_wAR, mem_wM, mem_R
  );

endinterface

// File: rtl/mem_seq_lat_cnt.sv
// mem_seq_lat_cnt: loadable down-counter with a registered zero flag, used to
// time the pointer-wait and data-wait states.
module mem_seq_lat_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  // Next count: load wins over decrement, saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count and zero-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mem_seq.sv
// mem_seq: memory access sequencer, initiator side of the data-memory port.
// Accepts one read/write request at a time, sequences AR loads, the optional
// pointer indirection and the synchronous-read wait, and returns a one-cycle
// response pulse. Indirect addressing is built only when
// HRM_MEMSEQ_INDIRECT_EN is defined; otherwise req_ind is ignored.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_seq_if.slave  bus
);

  localparam int unsigned       CNT_W    = cnt_width(READ_LAT);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic req_ready_q, req_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic war_q, war_d;
  logic wm_q, wm_d;
  logic srca_q, srca_d;

  logic accept_c;
  logic cnt_load_c;
  logic cnt_dec_c;
  logic cnt_zero;

  mem_seq_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load_c),
    .dec_i  (cnt_dec_c),
    .val_i  (CNT_LOAD),
    .zero_o (cnt_zero)
  );

  // Next state, request latch, capture data and registered-output next values
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_data_d  = rsp_data_q;
    cnt_load_c  = 1'b0;
    cnt_dec_c   = 1'b0;
    accept_c    = bus.req_valid && req_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d.op[OPF_WE]  = bus.req_we;
`ifdef HRM_MEMSEQ_INDIRECT_EN
          req_d.op[OPF_IND] = bus.req_ind;
`else
          req_d.op[OPF_IND] = 1'b0;
`endif
          req_d.addr        = bus.req_addr;
          req_d.wdata       = bus.req_wdata;
          state_d           = ST_LDAR;
        end
      end

      ST_LDAR: begin
`ifdef HRM_MEMSEQ_INDIRECT_EN
        if (req_q.op[OPF_IND]) begin
          state_d    = ST_PWAIT;
          cnt_load_c = 1'b1;
        end else
`endif
        if (req_q.op[OPF_WE]) begin
          state_d = ST_WR;
        end else begin
          state_d    = ST_DWAIT;
          cnt_load_c = 1'b1;
        end
      end

`ifdef HRM_MEMSEQ_INDIRECT_EN
      ST_PWAIT: begin
        if (cnt_zero) begin
          state_d = ST_LDIND;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end

      ST_LDIND: begin
        if (req_q.op[OPF_WE]) begin
          state_d = ST_WR;
        end else begin
          state_d    = ST_DWAIT;
          cnt_load_c = 1'b1;
        end
      end
`endif

      ST_DWAIT: begin
        if (cnt_zero) begin
          state_d = ST_CAP;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end

      ST_CAP: begin
        rsp_data_d = bus.mem_M;
        state_d    = ST_RSP;
      end

      ST_WR: begin
        state_d = ST_RSP;
      end

      ST_RSP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they line up with state_q
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);
    war_d       = (state_d == ST_LDAR) || (state_d == ST_LDIND);
    wm_d        = (state_d == ST_WR);
`ifdef HRM_MEMSEQ_INDIRECT_EN
    srca_d      = (state_d == ST_LDIND);
`else
    srca_d      = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, response data and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      war_q       <= 1'b0;
      wm_q        <= 1'b0;
      srca_q      <= 1'b0;
    end else begin
      req_q       <= req_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      war_q       <= war_d;
      wm_q        <= wm_d;
      srca_q      <= srca_d;
    end
  end

`ifndef HRM_MEMSEQ_INDIRECT_EN
  // Indirect flag has no consumer in the direct-only build
  logic unused_ind;
  assign unused_ind = bus.req_ind ^ req_q.op[OPF_IND];
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_R     = req_q.wdata;
  assign bus.mem_wAR   = war_q;
  assign bus.mem_wM    = wm_q;
  assign bus.mem_srcA  = srca_q;

endmodule
